count_down_mc: RTL and testbench

Multi-channel count-down timer, successor to the single-channel hh:mm:ss count-down block in the clock datapath. Holds CHANNELS independent hh:mm:ss timers sharing one prescaler that derives a 1 s tick from the system clock. Each channel has load/start/pause/clear control, an expiry flag and a per-channel state machine. One selectable channel is read back for the display mux.

---
 rtl/count_down_pkg.sv | 46 ++++
 rtl/count_down_mc_tick_gen.sv | 26 ++
 rtl/count_down_mc.sv | 160 ++++++++++++++++
 tb/tb_count_down_mc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_down_pkg.sv
// Shared types and helpers for the multi-channel hh:mm:ss count-down timer.
// Holds the channel FSM encoding, field limits and the clamp/decrement helpers.
package count_down_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] SEC_MAX = 8'd59;
    localparam logic [7:0] MIN_MAX = 8'd59;

    typedef struct packed {
        logic [7:0] hrs;
        logic [7:0] mins;
        logic [7:0] secs;
    } hms_t;

    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic logic is_zero(input hms_t t);
        return (t == '0);
    endfunction

    // Borrows through seconds, minutes, hours; 00:00:00 stays put.
    function automatic hms_t dec_hms(input hms_t t);
        hms_t r;
        r = t;
        if (t.secs != 8'd0) begin
            r.secs = t.secs - 8'd1;
        end else if (t.mins != 8'd0) begin
            r.secs = SEC_MAX;
            r.mins = t.mins - 8'd1;
        end else if (t.hrs != 8'd0) begin
            r.secs = SEC_MAX;
            r.mins = MIN_MAX;
            r.hrs  = t.hrs - 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/count_down_mc_tick_gen.sv
// Shared free-running prescaler: one-cycle tick every CLK_HZ enabled cycles.
module tick_gen #(
    parameter int CLK_HZ = 1000
) (
    input  logic CLK,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    always_ff @(posedge CLK) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/count_down_mc.sv
// CHANNELS independent hh:mm:ss count-down timers on one shared 1 s tick, with registered read-back.
// Build option: define COUNT_DOWN_AUTO_RELOAD_EN to reload the loaded value on expiry instead of stopping.
module count_down_mc
    import count_down_pkg::*;
#(
    parameter int CLK_HZ   = 1000,
    parameter int CHANNELS = 2,
    parameter int HRS_MAX  = 23,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                en,
    input  logic [CW-1:0]       ch_sel,
    input  logic                load,
    input  logic [7:0]          ld_hrs,
    input  logic [7:0]          ld_mins,
    input  logic [7:0]          ld_secs,
    input  logic                start,
    input  logic                pause,
    input  logic                clr,
    input  logic [CW-1:0]       rd_sel,
    output logic [7:0]          hrs,
    output logic [7:0]          mins,
    output logic [7:0]          seconds,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] expired,
    output logic                valid
);

    localparam logic [7:0] HRS_MAX8 = 8'(HRS_MAX);

    logic    tick;
    hms_t    ld_val;
    hms_t    ch_time [CHANNELS];
    hms_t    rd_val;
    logic [CW-1:0] rd_sel_q;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .CLK  (CLK),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    assign ld_val.hrs  = clamp8(ld_hrs, HRS_MAX8);
    assign ld_val.mins = clamp8(ld_mins, MIN_MAX);
    assign ld_val.secs = clamp8(ld_secs, SEC_MAX);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t st, st_nxt;
        hms_t   t, t_nxt;
        logic   ex, ex_nxt;
        logic   run_r, run_nxt;
        logic   sel;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
        hms_t   rl, rl_nxt;
`endif

        assign sel        = (ch_sel == CW'(i));
        assign ch_time[i] = t;
        assign running[i] = run_r;
        assign expired[i] = ex;

        always_ff @(posedge CLK) begin
            if (rst) begin
                st    <= ST_IDLE;
                t     <= '0;
                ex    <= 1'b0;
                run_r <= 1'b0;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
                rl    <= '0;
`endif
            end else begin
                st    <= st_nxt;
                t     <= t_nxt;
                ex    <= ex_nxt;
                run_r <= run_nxt;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
                rl    <= rl_nxt;
`endif
            end
        end

        // Commands for this channel pre-empt its tick; an ignored start still consumes the cycle.
        always_comb begin
            st_nxt = st;
            t_nxt  = t;
            ex_nxt = ex;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
            rl_nxt = rl;
`endif
            if (sel && clr) begin
                st_nxt = ST_IDLE;
                t_nxt  = '0;
                ex_nxt = 1'b0;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
                rl_nxt = '0;
`endif
            end else if (sel && load) begin
                st_nxt = ST_IDLE;
                t_nxt  = ld_val;
                ex_nxt = 1'b0;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
                rl_nxt = ld_val;
`endif
            end else if (sel && start) begin
                if (!is_zero(t)) begin
                    st_nxt = ST_RUN;
                    ex_nxt = 1'b0;
                end
            end else if (sel && pause) begin
                if (st == ST_RUN) begin
                    st_nxt = ST_PAUSE;
                end
            end else if (tick && (st == ST_RUN)) begin
                t_nxt = dec_hms(t);
                if (is_zero(t_nxt)) begin
                    ex_nxt = 1'b1;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
                    t_nxt  = rl;
`else
                    st_nxt = ST_DONE;
`endif
                end
            end
        end

        always_comb begin
            run_nxt = (st_nxt == ST_RUN);
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_sel == CW'(i)) begin
                rd_val = ch_time[i];
            end
        end
    end

    // Read-back is one cycle behind the channel registers; valid flags a new value or a new selection.
    always_ff @(posedge CLK) begin
        if (rst) begin
            hrs      <= 8'd0;
            mins     <= 8'd0;
            seconds  <= 8'd0;
            valid    <= 1'b0;
            rd_sel_q <= '0;
        end else begin
            hrs      <= rd_val.hrs;
            mins     <= rd_val.mins;
            seconds  <= rd_val.secs;
            valid    <= (rd_val != {hrs, mins, seconds}) || (rd_sel != rd_sel_q);
            rd_sel_q <= rd_sel;
        end
    end

endmodule

// File: tb/tb_count_down_mc.sv
// Randomised and directed bench for count_down_mc against a total-seconds reference model.
module tb_count_down_mc;

  localparam int CLK_HZ   = 4;
  localparam int CHANNELS = 2;
  localparam int HRS_MAX  = 23;
  localparam int CW       = 1;
  localparam int W        = 24;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b1;
  logic [CW-1:0]       ch_sel = '0;
  logic                load = 1'b0;
  logic [7:0]          ld_hrs = '0;
  logic [7:0]          ld_mins = '0;
  logic [7:0]          ld_secs = '0;
  logic                start = 1'b0;
  logic                pause = 1'b0;
  logic                clr = 1'b0;
  logic [CW-1:0]       rd_sel = '0;
  logic [7:0]          hrs, mins, seconds;
  logic [CHANNELS-1:0] running, expired;
  logic                valid;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  logic [W-1:0] exp_q[$];

  count_down_mc #(.CLK_HZ(CLK_HZ), .CHANNELS(CHANNELS), .HRS_MAX(HRS_MAX)) dut (
    .CLK(clk), .rst(rst), .en(en), .ch_sel(ch_sel), .load(load),
    .ld_hrs(ld_hrs), .ld_mins(ld_mins), .ld_secs(ld_secs),
    .start(start), .pause(pause), .clr(clr), .rd_sel(rd_sel),
    .hrs(hrs), .mins(mins), .seconds(seconds),
    .running(running), .expired(expired), .valid(valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] to_hms(input int t);
    logic [W-1:0] r;
    r[23:16] = 8'(t / 3600);
    r[15:8]  = 8'((t / 60) % 60);
    r[7:0]   = 8'(t % 60);
    return r;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // reference model: each channel is a count of remaining seconds
  int m_t   [CHANNELS];
  int m_st  [CHANNELS];
  bit m_exp [CHANNELS];
  int m_rl  [CHANNELS];
  int m_pc = 0;
  int m_disp = 0;
  int m_rdp = 0;
  bit m_vld = 1'b0;

  always @(posedge clk) begin
    bit tk;
    int nd;
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        m_t[c] = 0; m_st[c] = M_IDLE; m_exp[c] = 1'b0; m_rl[c] = 0;
      end
      m_pc = 0; m_disp = 0; m_rdp = 0; m_vld = 1'b0;
    end else begin
      tk = en && (m_pc == CLK_HZ - 1);
      if (en) m_pc = tk ? 0 : m_pc + 1;
      nd = m_t[int'(rd_sel)];
      m_vld = (nd != m_disp) || (int'(rd_sel) != m_rdp);
      if (m_vld) exp_q.push_back(to_hms(nd));
      m_disp = nd;
      m_rdp = int'(rd_sel);
      for (int c = 0; c < CHANNELS; c++) begin
        bit s;
        s = (int'(ch_sel) == c);
        if (s && clr) begin
          m_t[c] = 0; m_st[c] = M_IDLE; m_exp[c] = 1'b0; m_rl[c] = 0;
        end else if (s && load) begin
          m_t[c] = min_i(int'(ld_hrs), HRS_MAX) * 3600 + min_i(int'(ld_mins), 59) * 60
                   + min_i(int'(ld_secs), 59);
          m_rl[c] = m_t[c]; m_st[c] = M_IDLE; m_exp[c] = 1'b0;
        end else if (s && start) begin
          if (m_t[c] != 0) begin
            m_st[c] = M_RUN; m_exp[c] = 1'b0;
          end
        end else if (s && pause) begin
          if (m_st[c] == M_RUN) m_st[c] = M_PAUSE;
        end else if (tk && m_st[c] == M_RUN) begin
          m_t[c] = m_t[c] - 1;
          if (m_t[c] == 0) begin
            m_exp[c] = 1'b1;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
            m_t[c] = m_rl[c];
`else
            m_st[c] = M_DONE;
`endif
          end
        end
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [CHANNELS-1:0] er, ee;
    if (mon_on) begin
      for (int c = 0; c < CHANNELS; c++) begin
        er[c] = (m_st[c] == M_RUN);
        ee[c] = m_exp[c];
      end
      chk("running", 32'(running), 32'(er));
      chk("expired", 32'(expired), 32'(ee));
      chk("valid", 32'(valid), 32'(m_vld));
      chk("display", 32'({hrs, mins, seconds}), 32'(to_hms(m_disp)));
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_valid", 32'(1), 32'(0));
        end else begin
          chk("sb_readback", 32'({hrs, mins, seconds}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 load, 1 start, 2 pause, 3 clr
  task automatic do_cmd(input int kind, input int ch, input int h, input int m, input int s);
    @(negedge clk);
    ch_sel = CW'(ch);
    ld_hrs = 8'(h); ld_mins = 8'(m); ld_secs = 8'(s);
    load = (kind == 0); start = (kind == 1); pause = (kind == 2); clr = (kind == 3);
    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0; clr = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    mon_on = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_display", 32'({hrs, mins, seconds}), 32'(0));
    chk("reset_running", 32'(running), 32'(0));
    chk("reset_expired", 32'(expired), 32'(0));

    // ch0 00:00:03 runs to expiry
    do_cmd(0, 0, 0, 0, 3);
    do_cmd(1, 0, 0, 0, 0);
    chk("ch0_running_after_start", 32'(running[0]), 32'(1));
    for (k = 0; k < 40 && running[0]; k++) @(negedge clk);
    chk("ch0_expire_bound", 32'(running[0]), 32'(0));
    @(negedge clk);
    chk("ch0_expired_value", 32'({hrs, mins, seconds}), 32'(0));
    chk("ch0_expired_flag", 32'(expired[0]), 32'(1));

    // ch1 hour borrow and load clamping
    rd_sel = 1'b1;
    do_cmd(0, 1, 1, 0, 0);
    do_cmd(1, 1, 0, 0, 0);
    for (k = 0; k < 12 && {hrs, mins, seconds} == 24'h010000; k++) @(negedge clk);
    chk("ch1_borrow", 32'({hrs, mins, seconds}), 32'h003B3B);
    do_cmd(0, 1, 2, 80, 99);
    idle(2);
    chk("ch1_clamp_ms", 32'({hrs, mins, seconds}), 32'h023B3B);
    do_cmd(0, 1, 30, 0, 0);
    idle(2);
    chk("ch1_clamp_h", 32'({hrs, mins, seconds}), 32'h170000);

    // pause freezes, start resumes, start on zero ignored
    rd_sel = 1'b0;
    do_cmd(0, 0, 0, 1, 0);
    do_cmd(1, 0, 0, 0, 0);
    idle(6);
    do_cmd(2, 0, 0, 0, 0);
    idle(40);
    chk("ch0_paused", 32'(running[0]), 32'(0));
    do_cmd(1, 0, 0, 0, 0);
    idle(10);
    chk("ch0_resumed", 32'(running[0]), 32'(1));
    do_cmd(3, 0, 0, 0, 0);
    do_cmd(1, 0, 0, 0, 0);
    chk("start_on_zero", 32'(running[0]), 32'(0));

    // clr to ch1 coincident with a tick
    do_cmd(0, 0, 0, 0, 50);
    do_cmd(1, 0, 0, 0, 0);
    do_cmd(0, 1, 0, 0, 50);
    do_cmd(1, 1, 0, 0, 0);
    for (k = 0; k < 8 && m_pc != CLK_HZ - 1; k++) @(negedge clk);
    ch_sel = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_tick_run1", 32'(running[1]), 32'(0));
    chk("clr_tick_exp1", 32'(expired[1]), 32'(0));
    chk("clr_tick_run0", 32'(running[0]), 32'(1));
    rd_sel = 1'b1;
    idle(2);
    chk("clr_tick_val1", 32'({hrs, mins, seconds}), 32'(0));

    // reset mid-count, then en low holds the prescaler
    rd_sel = 1'b0;
    idle(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_display", 32'({hrs, mins, seconds}), 32'(0));
    chk("midrst_running", 32'(running), 32'(0));
    chk("midrst_expired", 32'(expired), 32'(0));
    chk("midrst_valid", 32'(valid), 32'(0));
    en = 1'b0;
    do_cmd(0, 0, 0, 0, 10);
    do_cmd(1, 0, 0, 0, 0);
    idle(20);
    chk("en_low_hold", 32'({hrs, mins, seconds}), 32'h00000A);
    en = 1'b1;

`ifdef COUNT_DOWN_AUTO_RELOAD_EN
    do_cmd(0, 0, 0, 0, 2);
    do_cmd(1, 0, 0, 0, 0);
    for (k = 0; k < 20 && !expired[0]; k++) @(negedge clk);
    chk("reload_expired", 32'(expired[0]), 32'(1));
    chk("reload_running", 32'(running[0]), 32'(1));
    @(negedge clk);
    chk("reload_value", 32'({hrs, mins, seconds}), 32'h000002);
`endif

    // randomised phase
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(negedge clk);
      load = 1'b0; start = 1'b0; pause = 1'b0; clr = 1'b0; rst = 1'b0;
      r = $urandom_range(0, 999);
      ch_sel = CW'($urandom_range(0, CHANNELS - 1));
      ld_secs = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 15));
      ld_mins = 8'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 99) : 0);
      ld_hrs  = 8'(($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : 0);
      if (r < 30) load = 1'b1;
      else if (r < 110) start = 1'b1;
      else if (r < 140) pause = 1'b1;
      else if (r < 155) clr = 1'b1;
      else if (r < 165) begin start = 1'b1; pause = 1'b1; end
      else if (r < 167) rst = 1'b1;
      if ($urandom_range(0, 19) == 0) rd_sel = CW'($urandom_range(0, CHANNELS - 1));
      en = ($urandom_range(0, 19) != 0);
    end
    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0; clr = 1'b0; rst = 1'b0; en = 1'b1;
    idle(5);
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
